// File: rtl/cfu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cfu_pkg
//  Brief    : Shared types and constants for the CFU command scheduler:
//             scheduler state encoding, timeout response word, funct7 field
//             slice of the CPU function id and queued-command packing helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package cfu_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_e;

    // Response word returned when the engine never signals completion
    localparam logic [31:0] TIMEOUT_RSP = 32'hDEADBEEF;

    // funct7 lives in bits [9:3] of the CPU function id; [2:0] are unused
    localparam int c_FUNCT7_MSB = 9;
    localparam int c_FUNCT7_LSB = 3;
    localparam int c_FUNCT7_W   = c_FUNCT7_MSB - c_FUNCT7_LSB + 1;

    // Queued command word: {funct7, inputs_0, inputs_1}
    localparam int c_CMD_W = c_FUNCT7_W + 64;

    function automatic logic [c_CMD_W-1:0] pack_cmd(
        input logic [c_FUNCT7_W-1:0] f7,
        input logic [31:0]           in0,
        input logic [31:0]           in1
    );
        return {f7, in0, in1};
    endfunction

    function automatic logic [c_FUNCT7_W-1:0] cmd_f7(input logic [c_CMD_W-1:0] c);
        return c[c_CMD_W-1 -: c_FUNCT7_W];
    endfunction

    function automatic logic [31:0] cmd_in0(input logic [c_CMD_W-1:0] c);
        return c[63:32];
    endfunction

    function automatic logic [31:0] cmd_in1(input logic [c_CMD_W-1:0] c);
        return c[31:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/cfu_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : cfu_cmd_fifo
//  Brief    : In-order command queue. Push is refused while full even if a pop
//             happens in the same cycle (no bypass). Pointers wrap modulo
//             DEPTH; level reports the number of entries held.
//  Revision : 1.0 - initial release
// ============================================================================
module cfu_cmd_fifo #(
    parameter int WIDTH = 71,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_DEPTH_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      level_q;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (level_q == c_DEPTH_LVL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];

    // Full/empty gating keeps the pointers and level consistent
    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i  & ~empty_o;

    // Storage array: written on accepted push, contents need no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (w_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (w_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/cfu_cmd_sched.sv
`default_nettype none
// ============================================================================
//  Module   : cfu_cmd_sched
//  Brief    : CPU custom-function-unit command scheduler. Queues CPU commands,
//             issues them one at a time to a conv1d engine, waits (with a
//             timeout) for completion and returns one response per command
//             in acceptance order.
//  Revision : 1.0 - initial release
// ============================================================================
module cfu_cmd_sched
    import cfu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [9:0]                    cmd_payload_function_id,
    input  logic [31:0]                   cmd_payload_inputs_0,
    input  logic [31:0]                   cmd_payload_inputs_1,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [31:0]                   rsp_payload_outputs_0,
    output logic                          eng_en,
    output logic [6:0]                    eng_cmd,
    output logic [31:0]                   eng_inp0,
    output logic [31:0]                   eng_inp1,
    input  logic [31:0]                   eng_ret,
    input  logic                          eng_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT_CNT = CNT_W'(TIMEOUT);

    sched_state_e        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         rsp_q, rsp_d;
    logic                err_q, err_d;
    logic                eng_en_q, eng_en_d;
    logic [6:0]          eng_cmd_q, eng_cmd_d;
    logic [31:0]         eng_inp0_q, eng_inp0_d;
    logic [31:0]         eng_inp1_q, eng_inp1_d;
    logic                rdy_q;

    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [c_CMD_W-1:0]  w_head;
    logic [c_CMD_W-1:0]  w_cmd_word;
    logic                w_unused_fid;

    // Low function-id bits carry no meaning for this unit
    assign w_unused_fid = ^cmd_payload_function_id[c_FUNCT7_LSB-1:0];

    assign w_cmd_word = pack_cmd(cmd_payload_function_id[c_FUNCT7_MSB:c_FUNCT7_LSB],
                                 cmd_payload_inputs_0, cmd_payload_inputs_1);

    // rdy_q holds cmd_ready low while reset is asserted and for no longer
    assign cmd_ready = rdy_q & ~w_full;
    assign w_push    = cmd_valid & cmd_ready;

    cfu_cmd_fifo #(
        .WIDTH (c_CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (w_push),
        .wdata_i (w_cmd_word),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (fifo_level)
    );

    assign rsp_valid             = (state_q == ST_RESP);
    assign rsp_payload_outputs_0 = rsp_q;
    assign eng_en                = eng_en_q;
    assign eng_cmd               = eng_cmd_q;
    assign eng_inp0              = eng_inp0_q;
    assign eng_inp1              = eng_inp1_q;
    assign err_timeout           = err_q;
    assign busy                  = (state_q != ST_IDLE) || (fifo_level != '0);

    // Out-of-reset flag gating command acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // State, timeout counter, response and engine-drive registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rsp_q      <= '0;
            err_q      <= 1'b0;
            eng_en_q   <= 1'b0;
            eng_cmd_q  <= '0;
            eng_inp0_q <= '0;
            eng_inp1_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rsp_q      <= rsp_d;
            err_q      <= err_d;
            eng_en_q   <= eng_en_d;
            eng_cmd_q  <= eng_cmd_d;
            eng_inp0_q <= eng_inp0_d;
            eng_inp1_q <= eng_inp1_d;
        end
    end

    // Next-state logic; engine drive is registered on entry to ISSUE so that
    // eng_en is high exactly for the ISSUE cycle, and the entry is popped then
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rsp_d      = rsp_q;
        err_d      = err_q;
        eng_en_d   = 1'b0;
        eng_cmd_d  = eng_cmd_q;
        eng_inp0_d = eng_inp0_q;
        eng_inp1_d = eng_inp1_q;
        w_pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    state_d    = ST_ISSUE;
                    eng_en_d   = 1'b1;
                    eng_cmd_d  = cmd_f7(w_head);
                    eng_inp0_d = cmd_in0(w_head);
                    eng_inp1_d = cmd_in1(w_head);
                end
            end
            ST_ISSUE: begin
                w_pop   = 1'b1;
                cnt_d   = CNT_W'(1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion on the final counted cycle still wins over timeout
                if (eng_done) begin
                    rsp_d   = eng_ret;
                    state_d = ST_RESP;
                end else if (cnt_q == c_TIMEOUT_CNT) begin
                    rsp_d   = TIMEOUT_RSP;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: doc/cfu_cmd_sched.md
CFU_CMD_SCHED -- requirements
Module: cfu_cmd_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command queue depth (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles waited for engine completion.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  CPU command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_payload_function_id  input  10  funct7 in [9:3]; [2:0] ignored.
REQ-008 SHALL have ports cmd_payload_inputs_0 and cmd_payload_inputs_1  input  32 each  operands.
REQ-009 SHALL have port rsp_valid  output  1  response available.
REQ-010 SHALL have port rsp_ready  input  1  CPU takes response.
REQ-011 SHALL have port rsp_payload_outputs_0  output  32  result.
REQ-012 SHALL have ports eng_en  output  1, eng_cmd  output  7, eng_inp0 and eng_inp1  output  32  conv1d engine drive.
REQ-013 SHALL have ports eng_ret  input  32, eng_done  input  1  engine result and output-buffer-valid.
REQ-014 SHALL have ports busy  output  1, fifo_level  output  $clog2(FIFO_DEPTH)+1, err_timeout  output  1 (sticky).

Function
REQ-015 SHALL queue accepted commands {funct7, inputs_0, inputs_1} in an in-order FIFO; cmd_ready = not full; no push bypass when full, even if popping that cycle.
REQ-016 SHALL run FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; IDLE advances to ISSUE when FIFO non-empty.
REQ-017 ISSUE SHALL pop one entry and assert eng_en for exactly one cycle with eng_cmd/eng_inp0/eng_inp1 = entry fields; eng_en low in all other states, eng_* data held at last value.
REQ-018 WAIT SHALL capture eng_ret into the response register on the first cycle eng_done=1 and go to RESP; eng_done outside WAIT is ignored.
REQ-019 WAIT SHALL count cycles from 1; if count reaches TIMEOUT without eng_done, response register = 0xDEADBEEF, err_timeout set, go to RESP.
REQ-020 RESP SHALL hold rsp_valid=1 and stable rsp_payload_outputs_0 until rsp_valid&rsp_ready, then return to IDLE next cycle; exactly one response per accepted command, in acceptance order.
REQ-021 Latency SHALL be: command accepted at cycle 0 into empty FIFO -> eng_en at cycle 2 -> eng_done at cycle N -> rsp_valid at cycle N+1.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_level = entries held (0..FIFO_DEPTH); simultaneous push and pop leaves level unchanged.
REQ-023 busy SHALL be 1 whenever state != IDLE or fifo_level != 0.
REQ-024 err_timeout SHALL stay 1 until reset; later commands process normally.

Reset
REQ-025 reset_n low SHALL asynchronously force: state IDLE, FIFO empty, fifo_level 0, cmd_ready 0 while asserted, rsp_valid 0, rsp_payload_outputs_0 0, eng_en 0, eng_cmd 0, eng_inp0/1 0, busy 0, err_timeout 0, timeout counter 0.
REQ-026 Reset mid-operation SHALL discard queued and in-flight commands with no response; cmd_ready returns to 1 the first cycle after deassertion.

Structure
REQ-027 FSM state enum, TIMEOUT_RSP constant 32'hDEADBEEF and funct7 field slice constants SHALL live in shared package cfu_pkg.
REQ-028 Command FIFO SHALL be sub-module cfu_cmd_fifo (parameterised width/depth, push/pop/full/empty/level); FSM and timeout counter in top.

Verification
REQ-029 Single cmd funct7=5, in0=0x11, in1=0x22, engine done 3 cycles after eng_en with ret 0x1234 -> eng_cmd=5 for one cycle, rsp 0x1234 exactly 4 cycles after eng_en.
REQ-030 Five back-to-back cmds, engine stalled, depth 4 -> cmd_ready drops after 4th pop-less accept, all five responses returned in order once engine runs.
REQ-031 rsp_ready held low 10 cycles in RESP -> rsp_valid and payload stable, no further eng_en until handshake.
REQ-032 eng_done never asserted, TIMEOUT=8 -> rsp 0xDEADBEEF 9 cycles after eng_en, err_timeout=1, next cmd completes normally.
REQ-033 reset_n pulsed low in WAIT with 2 queued -> all outputs at reset values immediately, no responses, fifo_level 0.
REQ-034 eng_done pulsed in IDLE and RESP -> ignored, response values unchanged.
